// File: rtl/enemy_combat_tracker_if.sv
// Bus between the game-logic frame driver and one enemy combat slot.
// The master drives frame timing, positions and attack data.
// The slave reports health, lifecycle and kill count.
interface enemy_combat_tracker_if #(
  parameter int COORD_W = 9,
  parameter int HP_W    = 7,
  parameter int SCORE_W = 8
);
  logic               frame_tick;
  logic               Enable;
  logic [COORD_W-1:0] Enemy_X;
  logic [COORD_W-1:0] Enemy_Y;
  logic [COORD_W-1:0] Attack_X;
  logic [COORD_W-1:0] Attack_Y;
  logic [1:0]         Player_Direction;
  logic               Attack_On;
  logic [HP_W-1:0]    Damage;
  logic               Enemy_Alive;
  logic [HP_W-1:0]    Enemy_Blood;
  logic               Enemy_Is_Attacked;
  logic               Enemy_Dying;
  logic [SCORE_W-1:0] Kill_Count;

  modport master (
    output frame_tick, Enable, Enemy_X, Enemy_Y, Attack_X, Attack_Y,
           Player_Direction, Attack_On, Damage,
    input  Enemy_Alive, Enemy_Blood, Enemy_Is_Attacked, Enemy_Dying, Kill_Count
  );

  modport slave (
    input  frame_tick, Enable, Enemy_X, Enemy_Y, Attack_X, Attack_Y,
           Player_Direction, Attack_On, Damage,
    output Enemy_Alive, Enemy_Blood, Enemy_Is_Attacked, Enemy_Dying, Kill_Count
  );
endinterface

// File: rtl/enemy_combat_tracker.sv
// Per-enemy health and lifecycle controller: hitbox test for the four
// attack directions, damage with invulnerability frames, a dying phase,
// an ID-staggered respawn delay and a saturating kill counter.
module enemy_combat_tracker #(
  parameter int ID             = 0,
  parameter int COORD_W        = 9,
  parameter int HP_W           = 7,
  parameter int SCORE_W        = 8,
  parameter int FULL_HP        = 100,
  parameter int ENEMY_W        = 26,
  parameter int ENEMY_H        = 26,
  parameter int ATK_SHORT      = 16,
  parameter int ATK_LONG       = 80,
  parameter int INVULN_FRAMES  = 4,
  parameter int DYING_FRAMES   = 8,
  parameter int RESPAWN_FRAMES = 40,
  parameter int STAGGER_FRAMES = 40
) (
  input logic Clk,
  input logic Reset,
  enemy_combat_tracker_if.slave bus
);

  // Respawn delay in enabled frames, fixed at elaboration.
  localparam int D = RESPAWN_FRAMES + ID * STAGGER_FRAMES;
  localparam int T_MAX_A = (D > INVULN_FRAMES) ? D : INVULN_FRAMES;
  localparam int T_MAX   = (T_MAX_A > DYING_FRAMES) ? T_MAX_A : DYING_FRAMES;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  // Two guard bits so box edges plus offsets never wrap.
  localparam int CW = COORD_W + 2;

  typedef enum logic [1:0] {DEAD_WAIT, ALIVE, INVULN, DYING} state_t;

  state_t             state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [HP_W-1:0]    blood_reg;
  logic [SCORE_W-1:0] kills_reg;
  logic               attacked_reg;
  logic               alive_reg;
  logic               dying_reg;

  logic [CW-1:0] ex0, ex1, ey0, ey1, ax, ay;
  logic [3:0]    dir_overlap;
  logic          hit;

  assign ex0 = {2'b00, bus.Enemy_X};
  assign ey0 = {2'b00, bus.Enemy_Y};
  assign ex1 = ex0 + CW'(ENEMY_W);
  assign ey1 = ey0 + CW'(ENEMY_H);
  assign ax  = {2'b00, bus.Attack_X};
  assign ay  = {2'b00, bus.Attack_Y};

  // Each direction is an attack box [ax-XL, ax+XH] x [ay-YL, ay+YH]; the
  // subtracted extents are moved to the enemy side so no term can underflow.
  for (genvar gi = 0; gi < 4; gi++) begin : g_dir
    localparam int XL = (gi == 1) ? ATK_LONG : 0;
    localparam int XH = (gi == 0 || gi == 2) ? ATK_SHORT : ((gi == 3) ? ATK_LONG : 0);
    localparam int YL = (gi == 2) ? ATK_LONG : 0;
    localparam int YH = (gi == 0) ? ATK_LONG : ((gi == 1 || gi == 3) ? ATK_SHORT : 0);
    assign dir_overlap[gi] = (ex0 <= ax + CW'(XH)) && (ax <= ex1 + CW'(XL)) &&
                             (ey0 <= ay + CW'(YH)) && (ay <= ey1 + CW'(YL));
  end

  assign hit = bus.Attack_On & dir_overlap[bus.Player_Direction];

  // Lifecycle FSM with registered outputs; advances only on frame ticks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= DEAD_WAIT;
      timer_reg    <= '0;
      blood_reg    <= '0;
      kills_reg    <= '0;
      attacked_reg <= 1'b0;
      alive_reg    <= 1'b0;
      dying_reg    <= 1'b0;
    end else if (bus.frame_tick) begin
      attacked_reg <= 1'b0;
      case (state_reg)
        DEAD_WAIT: begin
          if (bus.Enable) begin
            if (timer_reg == TIMER_W'(D - 1)) begin
              blood_reg <= HP_W'(FULL_HP);
              timer_reg <= '0;
              alive_reg <= 1'b1;
              state_reg <= ALIVE;
            end else begin
              timer_reg <= timer_reg + TIMER_W'(1);
            end
          end
        end
        ALIVE: begin
          if (hit) begin
            attacked_reg <= 1'b1;
            timer_reg    <= '0;
            if (bus.Damage >= blood_reg) begin
              blood_reg <= '0;
              if (kills_reg != '1) kills_reg <= kills_reg + SCORE_W'(1);
              alive_reg <= 1'b0;
              dying_reg <= 1'b1;
              state_reg <= DYING;
            end else begin
              blood_reg <= blood_reg - bus.Damage;
              state_reg <= INVULN;
            end
          end
        end
        INVULN: begin
          if (timer_reg == TIMER_W'(INVULN_FRAMES - 1)) begin
            timer_reg <= '0;
            state_reg <= ALIVE;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        DYING: begin
          if (timer_reg == TIMER_W'(DYING_FRAMES - 1)) begin
            timer_reg <= '0;
            dying_reg <= 1'b0;
            state_reg <= DEAD_WAIT;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        default: state_reg <= DEAD_WAIT;
      endcase
    end
  end

  assign bus.Enemy_Alive       = alive_reg;
  assign bus.Enemy_Blood       = blood_reg;
  assign bus.Enemy_Is_Attacked = attacked_reg;
  assign bus.Enemy_Dying       = dying_reg;
  assign bus.Kill_Count        = kills_reg;

endmodule

// File: tb/tb_enemy_combat_tracker.sv
// Bench for enemy_combat_tracker (ID=1, respawn delay 80 frames): a vector
// table for hits and hitbox edges, plus hand sequences for respawn timing,
// wave pause, reset in INVULN and kill counter saturation.
module tb_enemy_combat_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enemy_combat_tracker_if #(.COORD_W(9), .HP_W(7), .SCORE_W(8)) bus ();

  enemy_combat_tracker #(.ID(1)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct {
    string    name;
    logic     alive;
    int       blood;
    logic     att;
    logic     dying;
    int       kills;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] dir;
    int         ax, ay, ex, ey;
    logic       on;
    int         dmg;
    logic       e_alive;
    int         e_blood;
    logic       e_att;
    logic       e_dying;
    int         e_kills;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_now(input string name, input logic a, input int blood,
                           input logic att, input logic dy, input int kills);
    check({name, ".alive"}, 32'(bus.Enemy_Alive), 32'(a));
    check({name, ".blood"}, 32'(bus.Enemy_Blood), blood);
    check({name, ".attacked"}, 32'(bus.Enemy_Is_Attacked), 32'(att));
    check({name, ".dying"}, 32'(bus.Enemy_Dying), 32'(dy));
    check({name, ".kills"}, 32'(bus.Kill_Count), kills);
  endtask

  task automatic drive(input logic [1:0] dir, input int ax, input int ay, input int ex,
                       input int ey, input logic on, input int dmg);
    bus.Player_Direction = dir;
    bus.Attack_X         = 9'(ax);
    bus.Attack_Y         = 9'(ay);
    bus.Enemy_X          = 9'(ex);
    bus.Enemy_Y          = 9'(ey);
    bus.Attack_On        = on;
    bus.Damage           = 7'(dmg);
  endtask

  // One frame: frame_tick high for a single Clk, outputs sampled on the
  // falling edge after the active edge.
  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic step_expect(input string name, input logic a, input int blood,
                             input logic att, input logic dy, input int kills);
    exp_t e;
    e.name = name; e.alive = a; e.blood = blood; e.att = att; e.dying = dy; e.kills = kills;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check_now(e.name, e.alive, e.blood, e.att, e.dying, e.kills);
    $display("txn %s alive=%0b blood=%0d attacked=%0b dying=%0b kills=%0d",
             e.name, bus.Enemy_Alive, bus.Enemy_Blood, bus.Enemy_Is_Attacked,
             bus.Enemy_Dying, bus.Kill_Count);
  endtask

  task automatic add(input string n, input logic [1:0] dir, input int ax, input int ay,
                     input int ex, input int ey, input logic on, input int dmg,
                     input logic ea, input int eb, input logic eat, input logic edy,
                     input int ek);
    vec_t v;
    v.name = n; v.dir = dir; v.ax = ax; v.ay = ay; v.ex = ex; v.ey = ey;
    v.on = on; v.dmg = dmg; v.e_alive = ea; v.e_blood = eb; v.e_att = eat;
    v.e_dying = edy; v.e_kills = ek;
    vecs.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.Enable     = 1'b1;
    drive(2'd0, 0, 0, 0, 0, 1'b0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_now("reset", 1'b0, 0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // Respawn on exactly the 80th enabled tick.
    repeat (78) tick();
    step_expect("respawn_t79", 1'b0, 0, 1'b0, 1'b0, 0);
    step_expect("respawn_t80", 1'b1, 100, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check_now("hold_between_ticks", 1'b1, 100, 1'b0, 1'b0, 0);

    // Hit / invulnerability / hitbox-edge table.
    add("d3_hit",        2'd3, 100, 100, 170, 100, 1'b1, 10, 1'b1, 90, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add("invuln_hold", 2'd3, 100, 100, 170, 100, 1'b1, 10, 1'b1, 90, 1'b0, 1'b0, 0);
    add("d3_after_inv",  2'd3, 100, 100, 170, 100, 1'b1, 10, 1'b1, 80, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add("idle_a",      2'd3, 100, 100, 170, 100, 1'b0, 10, 1'b1, 80, 1'b0, 1'b0, 0);
    add("d1_edge_hit",   2'd1, 20, 50, 0, 50, 1'b1, 5, 1'b1, 75, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add("idle_b",      2'd1, 20, 50, 0, 50, 1'b0, 5, 1'b1, 75, 1'b0, 1'b0, 0);
    add("d1_no_hit",     2'd1, 20, 50, 21, 50, 1'b1, 5, 1'b1, 75, 1'b0, 1'b0, 0);
    add("d0_dmg0",       2'd0, 200, 200, 210, 270, 1'b1, 0, 1'b1, 75, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add("idle_c",      2'd0, 200, 200, 210, 270, 1'b0, 0, 1'b1, 75, 1'b0, 1'b0, 0);
    add("d2_edge_hit",   2'd2, 300, 300, 310, 194, 1'b1, 45, 1'b1, 30, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      add("idle_d",      2'd2, 300, 300, 310, 194, 1'b0, 45, 1'b1, 30, 1'b0, 1'b0, 0);
    add("d2_no_hit",     2'd2, 300, 300, 310, 193, 1'b1, 45, 1'b1, 30, 1'b0, 1'b0, 0);
    add("d3_x_no_hit",   2'd3, 100, 100, 181, 100, 1'b1, 5, 1'b1, 30, 1'b0, 1'b0, 0);
    add("d3_lethal",     2'd3, 100, 100, 180, 100, 1'b1, 50, 1'b0, 0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 7; i++)
      add("dying",       2'd3, 100, 100, 180, 100, 1'b1, 50, 1'b0, 0, 1'b0, 1'b1, 1);
    add("dying_end",     2'd3, 100, 100, 180, 100, 1'b1, 50, 1'b0, 0, 1'b0, 1'b0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].dir, vecs[i].ax, vecs[i].ay, vecs[i].ex, vecs[i].ey, vecs[i].on, vecs[i].dmg);
      step_expect(vecs[i].name, vecs[i].e_alive, vecs[i].e_blood, vecs[i].e_att,
                  vecs[i].e_dying, vecs[i].e_kills);
    end

    // Respawn 80 ticks after entering DEAD_WAIT.
    drive(2'd3, 100, 100, 170, 100, 1'b0, 0);
    repeat (78) tick();
    step_expect("respawn2_t79", 1'b0, 0, 1'b0, 1'b0, 1);
    step_expect("respawn2_t80", 1'b1, 100, 1'b0, 1'b0, 1);

    // Wave pause: 20 disabled ticks delay respawn by exactly 20 ticks.
    drive(2'd3, 100, 100, 170, 100, 1'b1, 127);
    step_expect("kill2", 1'b0, 0, 1'b1, 1'b1, 2);
    bus.Attack_On = 1'b0;
    repeat (7) tick();
    step_expect("dying_end2", 1'b0, 0, 1'b0, 1'b0, 2);
    repeat (10) tick();
    bus.Enable = 1'b0;
    repeat (19) tick();
    step_expect("paused", 1'b0, 0, 1'b0, 1'b0, 2);
    bus.Enable = 1'b1;
    repeat (68) tick();
    step_expect("resume_t79", 1'b0, 0, 1'b0, 1'b0, 2);
    step_expect("resume_t80", 1'b1, 100, 1'b0, 1'b0, 2);

    // Reset while in INVULN.
    drive(2'd3, 100, 100, 170, 100, 1'b1, 10);
    step_expect("hit_before_reset", 1'b1, 90, 1'b1, 1'b0, 2);
    bus.Attack_On = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_now("reset_in_invuln", 1'b0, 0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // Kill counter saturation at 255.
    for (int k = 1; k <= 256; k++) begin
      drive(2'd3, 100, 100, 170, 100, 1'b0, 127);
      repeat (80) tick();
      bus.Attack_On = 1'b1;
      tick();
      check("sat_kill", 32'(bus.Kill_Count), (k > 255) ? 255 : k);
      if (k == 1 || k == 255 || k == 256)
        $display("txn sat_kill k=%0d kills=%0d", k, bus.Kill_Count);
      bus.Attack_On = 1'b0;
      repeat (8) tick();
    end
    check_now("sat_final", 1'b0, 0, 1'b0, 1'b0, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_combat_tracker.md
Name: enemy_combat_tracker

Overview:
Per-enemy health and lifecycle controller for the boxhead game, one instance per enemy slot, in the game-logic layer between the player/attack position logic and the enemy sprite/score logic.
- Hitbox overlap is tested once per game frame for all four attack directions.
- Damage comes from a runtime input and saturates at zero.
- Adds invulnerability frames and a dying animation phase.
- Respawn delay is parametrised and staggered per ID.
- Outputs a saturating kill counter and a one-frame hit flag.

Parameters:
- ID, 0, enemy slot index; staggers respawn delay.
- COORD_W, 9, width of all X/Y coordinates.
- HP_W, 7, width of health and damage.
- SCORE_W, 8, width of kill counter.
- FULL_HP, 100, health loaded on spawn.
- ENEMY_W, 26, enemy box width in pixels.
- ENEMY_H, 26, enemy box height in pixels.
- ATK_SHORT, 16, attack box short side.
- ATK_LONG, 80, attack box long side.
- INVULN_FRAMES, 4, frames ignored after a non-lethal hit.
- DYING_FRAMES, 8, frames spent in death animation.
- RESPAWN_FRAMES, 40, base respawn delay in frames.
- STAGGER_FRAMES, 40, extra delay per ID.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- frame_tick  in  1  one-Clk pulse per game frame; all state changes occur only on cycles where it is high
- Enable  in  1  0 freezes the respawn countdown (wave pause)
- Enemy_X, Enemy_Y  in  COORD_W  enemy top-left corner
- Attack_X, Attack_Y  in  COORD_W  attack origin
- Player_Direction  in  2  0 down, 1 left, 2 up, 3 right
- Attack_On  in  1  player attack active this frame
- Damage  in  HP_W  damage applied per registered hit
- Enemy_Alive  out  1  high in ALIVE and INVULN
- Enemy_Blood  out  HP_W  current health
- Enemy_Is_Attacked  out  1  high for exactly one frame after a registered hit
- Enemy_Dying  out  1  high in DYING
- Kill_Count  out  SCORE_W  kills, saturating

Behaviour:
Reset values:
- State DEAD_WAIT, timer 0, Enemy_Blood 0, Kill_Count 0.
- Enemy_Is_Attacked 0, Enemy_Alive 0, Enemy_Dying 0.
- Reset mid-operation returns everything to these values on the next Clk.

Respawn delay:
- D = RESPAWN_FRAMES + ID*STAGGER_FRAMES, computed as an elaboration-time constant.

Hitbox overlap:
- All tests use inclusive comparisons evaluated at COORD_W+2 bits, with no subtraction, so nothing wraps.
- Enemy box is [Enemy_X, Enemy_X+ENEMY_W] x [Enemy_Y, Enemy_Y+ENEMY_H].
- Dir 0: attack box [AX, AX+ATK_SHORT] x [AY, AY+ATK_LONG].
- Dir 1: attack box [AX-ATK_LONG, AX] x [AY, AY+ATK_SHORT]. Left bound is tested as Enemy_X+ENEMY_W+ATK_LONG >= AX.
- Dir 2: attack box [AX, AX+ATK_SHORT] x [AY-ATK_LONG, AY]. Top bound is tested as Enemy_Y+ENEMY_H+ATK_LONG >= AY.
- Dir 3: attack box [AX, AX+ATK_LONG] x [AY, AY+ATK_SHORT].
- hit = Attack_On & overlap, sampled on frame_tick.

FSM (advances only on frame_tick):
- DEAD_WAIT:
  - If Enable, timer increments; Enable=0 holds the timer.
  - On the tick where timer == D-1: Enemy_Blood <= FULL_HP, timer <= 0, go to ALIVE.
  - ALIVE is therefore reached on exactly the D-th enabled tick.
- ALIVE, on a hit:
  - If Damage >= Enemy_Blood: Enemy_Blood <= 0, Kill_Count increments (holds at all-ones), go to DYING.
  - Otherwise: Enemy_Blood <= Enemy_Blood - Damage, go to INVULN, timer <= 0.
  - Damage = 0 still counts as a hit: flag pulses and INVULN is entered.
- INVULN:
  - Hits are ignored.
  - After INVULN_FRAMES ticks (timer reaches INVULN_FRAMES-1), go to ALIVE.
- DYING:
  - After DYING_FRAMES ticks, go to DEAD_WAIT, timer <= 0.
  - Hits are ignored.
- Enemy_Is_Attacked:
  - Registered; set on the tick a hit is registered (lethal or not).
  - Cleared on the next frame_tick.
- Latency: outputs update on the Clk edge ending the frame_tick cycle.
- Between ticks all outputs hold.

Test Plan:
1. Reset, ID=1, Enable=1, 80 ticks: Enemy_Alive rises after tick 80 (not 79); Enemy_Blood=100.
2. Alive; Dir 3, Attack=(100,100), Enemy=(170,100), Damage=10, Attack_On on one tick -> Blood=90, Enemy_Is_Attacked high exactly one frame, INVULN. Attack held for 4 more ticks -> Blood stays 90. Fifth tick -> Blood=80.
3. Dir 1 edge: Attack_X=20, Enemy_X=0 -> no wrap, hit registered. Enemy_X=Attack_X+1 -> no hit.
4. Blood=30, Damage=50 -> Blood=0, Kill_Count +1, Enemy_Dying for 8 ticks, then DEAD_WAIT; respawn after 80 more ticks.
5. Kill_Count=255, another kill -> stays 255.
6. Enable=0 during DEAD_WAIT for 20 ticks -> respawn delayed by exactly 20 ticks. Reset asserted in INVULN -> all outputs return to reset values after one Clk.
